// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the threshold FIFO family.
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  function automatic int ptr_width(input int log_depth);
    return log_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo_thr: synchronous write, read port
// registered by default and combinational when SYNC_FIFO_FWFT_EN is defined.
module fifo_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [(1 << ADDR_W)];

  // Storage write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem_r[raddr];
`else
  // Read port samples every cycle; the top only consumes it after an accepted pop.
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds and
// overflow/underflow reporting. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_thr
  import fifo_pkg::*;
#(
  parameter int LOG_DEPTH = 4,
  parameter int D_WIDTH   = 32,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_en,
  input  logic [D_WIDTH-1:0] data_w,
  input  logic               r_en,
  output logic [D_WIDTH-1:0] data_r,
  output logic               o_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [LOG_DEPTH:0] level,
  output logic               overflow,
  output logic               underflow,
  output logic [1:0]         err_sticky,
  input  logic               err_clr
);

  localparam int PW = ptr_width(LOG_DEPTH);

  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [PW-1:0]      level_s;
  logic               full_s;
  logic               empty_s;
  logic               wr_acc_s;
  logic               rd_acc_s;
  logic               ovf_r;
  logic               udf_r;
  logic [1:0]         err_r;
  logic [1:0]         err_set_s;
  logic [D_WIDTH-1:0] ram_rdata_s;

  assign level_s  = wr_ptr_r - rd_ptr_r;
  assign full_s   = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                    (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign wr_acc_s = w_en && !full_s;
  assign rd_acc_s = r_en && !empty_s;

  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (level_s >= PW'(AF_THRESH));
  assign almost_empty = (level_s <= PW'(AE_THRESH));
  assign level        = level_s;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;
  assign err_sticky   = err_r;

  fifo_ram #(
    .ADDR_W (LOG_DEPTH),
    .DATA_W (D_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r[PW-2:0]),
    .wdata (data_w),
    .raddr (rd_ptr_r[PW-2:0]),
    .rdata (ram_rdata_s)
  );

  // Pointer advance on accepted transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Error set vector; a fresh event outranks a simultaneous clear.
  always_comb begin
    err_set_s           = 2'b00;
    err_set_s[ERR_OVF]  = w_en && full_s;
    err_set_s[ERR_UDF]  = r_en && empty_s;
  end

  // Attempt pulses and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
      err_r <= 2'b00;
    end else begin
      ovf_r <= err_set_s[ERR_OVF];
      udf_r <= err_set_s[ERR_UDF];
      err_r <= (err_r & ~{2{err_clr}}) | err_set_s;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_valid = !empty_s;
  assign data_r  = empty_s ? {D_WIDTH{1'b0}} : ram_rdata_s;
`else
  logic               o_valid_r;
  logic [D_WIDTH-1:0] data_hold_r;

  // Popped word is live on the RAM port for one cycle, then captured so data_r holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_r   <= 1'b0;
      data_hold_r <= {D_WIDTH{1'b0}};
    end else begin
      o_valid_r <= rd_acc_s;
      if (o_valid_r) begin
        data_hold_r <= ram_rdata_s;
      end
    end
  end

  assign o_valid = o_valid_r;
  assign data_r  = o_valid_r ? ram_rdata_s : data_hold_r;
`endif

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed self-checking bench for sync_fifo_thr (default parameters, either read mode).
module tb_sync_fifo_thr;

  logic        clk;
  logic        rst_n;
  logic        w_en;
  logic [31:0] data_w;
  logic        r_en;
  logic [31:0] data_r;
  logic        o_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;
  logic [1:0]  err_sticky;
  logic        err_clr;

  int checks;
  int errors;
  logic [31:0] model_q [$];

  sync_fifo_thr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_en         (w_en),
    .data_w       (data_w),
    .r_en         (r_en),
    .data_r       (data_r),
    .o_valid      (o_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_w = 32'h0;
    tick();
    tick();
    checks++;
    if ({level, empty, full, almost_empty, almost_full, o_valid, overflow, underflow, err_sticky} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_flags: level=%0d e=%b f=%b ae=%b af=%b v=%b ovf=%b udf=%b err=%b, required 0 1 0 1 0 0 0 0 00",
               level, empty, full, almost_empty, almost_full, o_valid, overflow, underflow, err_sticky);
    end
    checks++;
    if (data_r !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", data_r);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; data_w = 32'(i);
      model_q.push_back(32'(i));
      tick();
      checks++;
      if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || almost_empty !== (i + 1 <= 2)) begin
        errors++;
        $display("FAIL fill_level[%0d]: level=%0d af=%b ae=%b, required %0d %b %b",
                 i, level, almost_full, almost_empty, i + 1, (i + 1 >= 12), (i + 1 <= 2));
      end
    end
    w_en = 1'b0;
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b empty=%b, required 1 0", full, empty);
    end
  endtask

  task automatic test_overflow();
    w_en = 1'b1; r_en = 1'b1; data_w = 32'hDEAD_BEEF;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || err_sticky !== 2'b01 || level !== 5'd15) begin
      errors++;
      $display("FAIL ovf_pulse: ovf=%b err=%b level=%0d, required 1 01 15", overflow, err_sticky, level);
    end
    void'(model_q.pop_front());
    // Refill the popped slot, then attempt a plain write while full
    w_en = 1'b1; data_w = 32'h0000_0010; model_q.push_back(32'h10);
    tick();
    checks++;
    if (overflow !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_one_cycle: ovf=%b level=%0d, required 0 16", overflow, level);
    end
    data_w = 32'hBAD0_BAD0;
    tick();
    w_en = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0 || err_sticky !== 2'b01 || level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_after: ovf=%b err=%b level=%0d, required 0 01 16", overflow, err_sticky, level);
    end
  endtask

  task automatic test_drain();
    logic [31:0] exp;
    int n;
    n = model_q.size();
    for (int i = 0; i < n; i++) begin
      exp = model_q.pop_front();
      r_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (o_valid !== 1'b1 || data_r !== exp) begin
        errors++;
        $display("FAIL drain_data[%0d]: v=%b data=%h, required 1 %h", i, o_valid, data_r, exp);
      end
      tick();
`else
      tick();
      checks++;
      if (o_valid !== 1'b1 || data_r !== exp) begin
        errors++;
        $display("FAIL drain_data[%0d]: v=%b data=%h, required 1 %h", i, o_valid, data_r, exp);
      end
`endif
    end
    r_en = 1'b0;
    tick();
    checks++;
    if (empty !== 1'b1 || o_valid !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b v=%b level=%0d, required 1 0 0", empty, o_valid, level);
    end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (data_r !== 32'h10) begin
      errors++;
      $display("FAIL drain_hold: data=%h, required 10", data_r);
    end
`endif
  endtask

  task automatic test_underflow();
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    checks++;
    if (underflow !== 1'b1 || o_valid !== 1'b0 || err_sticky !== 2'b11) begin
      errors++;
      $display("FAIL udf_pulse: udf=%b v=%b err=%b, required 1 0 11", underflow, o_valid, err_sticky);
    end
    tick();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL udf_one_cycle: udf=%b, required 0", underflow);
    end
    err_clr = 1'b1;
    tick();
    checks++;
    if (err_sticky !== 2'b00) begin
      errors++;
      $display("FAIL err_clr: err=%b, required 00", err_sticky);
    end
    r_en = 1'b1;
    tick();
    r_en = 1'b0; err_clr = 1'b0;
    checks++;
    if (err_sticky !== 2'b10) begin
      errors++;
      $display("FAIL set_wins: err=%b, required 10", err_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; data_w = 32'h100 + 32'(i);
      model_q.push_back(data_w);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      exp = model_q.pop_front();
      w_en = 1'b1; r_en = 1'b1; data_w = 32'h200 + 32'(k);
      model_q.push_back(data_w);
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (o_valid !== 1'b1 || data_r !== exp) begin
        errors++;
        $display("FAIL b2b_data[%0d]: v=%b data=%h, required 1 %h", k, o_valid, data_r, exp);
      end
      tick();
`else
      tick();
      checks++;
      if (o_valid !== 1'b1 || data_r !== exp) begin
        errors++;
        $display("FAIL b2b_data[%0d]: v=%b data=%h, required 1 %h", k, o_valid, data_r, exp);
      end
`endif
      checks++;
      if (level !== 5'd8) begin
        errors++;
        $display("FAIL b2b_level[%0d]: level=%0d, required 8", k, level);
      end
    end
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      exp = model_q.pop_front();
      r_en = 1'b1;
      tick();
    end
    r_en = 1'b0;
    tick();
    checks++;
    if (level !== 5'd5 || almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL mid_level: level=%0d ae=%b, required 5 0", level, almost_empty);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_q.delete();
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || data_r !== 32'h0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: level=%0d empty=%b data=%h v=%b, required 0 1 0 0", level, empty, data_r, o_valid);
    end
    w_en = 1'b1; data_w = 32'hA5;
    tick();
    w_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (o_valid !== 1'b1 || data_r !== 32'hA5) begin
      errors++;
      $display("FAIL mid_first: v=%b data=%h, required 1 a5", o_valid, data_r);
    end
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
`else
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || data_r !== 32'hA5) begin
      errors++;
      $display("FAIL mid_first: v=%b data=%h, required 1 a5", o_valid, data_r);
    end
`endif
    tick();
    checks++;
    if (empty !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_empty: empty=%b v=%b, required 1 0", empty, o_valid);
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    w_en = 1'b1; data_w = 32'h11;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwft_pre: v=%b, required 0", o_valid);
    end
    tick();
    w_en = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || data_r !== 32'h11) begin
      errors++;
      $display("FAIL fwft_fall: v=%b data=%h, required 1 11", o_valid, data_r);
    end
    tick();
    checks++;
    if (o_valid !== 1'b1 || data_r !== 32'h11) begin
      errors++;
      $display("FAIL fwft_hold: v=%b data=%h, required 1 11", o_valid, data_r);
    end
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL fwft_pop: v=%b empty=%b, required 0 1", o_valid, empty);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
